// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF pair counter.
// Holds the FSM encoding and the timer width helper.
package ro_puf_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int WINDOW_DEF      = 4096;
  localparam int SETTLE_DEF      = 16;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_CMP
  } state_t;

  function automatic int tmr_w(input int window,
                               input int settle);
    int m;
    m = (window > settle) ? window : settle;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Multi-stage synchronizer for an oscillator output
// with a one-cycle rising-edge pulse.
module ro_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/ro_pair_counter.sv
// Counts edges of two ring oscillators over a fixed window
// and reports which one is faster.
module ro_pair_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int SETTLE      = SETTLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_enable,
  output logic             ro_reset,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam int TW = tmr_w(WINDOW, SETTLE);
  localparam logic [TW-1:0] SET_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0] WIN_LD = TW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           state;
  logic [TW-1:0]    tmr;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] nxt_a;
  logic [CNT_W-1:0] nxt_b;
  logic             rise_a;
  logic             rise_b;

  ro_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .din   (ro_a),
    .rise  (rise_a)
  );

  ro_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .din   (ro_b),
    .rise  (rise_b)
  );

  // Saturating increments; the last COUNT cycle's edge
  // is folded into the result latched on the CMP entry.
  always_comb begin
    nxt_a = cnt_a;
    nxt_b = cnt_b;
    if (rise_a && cnt_a != CMAX)
      nxt_a = cnt_a + 1'b1;
    if (rise_b && cnt_b != CMAX)
      nxt_b = cnt_b + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      ro_enable <= 1'b0;
      ro_reset  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      response  <= 1'b0;
      tie       <= 1'b0;
      count_a   <= '0;
      count_b   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SETTLE;
            tmr       <= SET_LD;
            cnt_a     <= '0;
            cnt_b     <= '0;
            ro_enable <= 1'b1;
            ro_reset  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr == '0) begin
            state <= ST_COUNT;
            tmr   <= WIN_LD;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_COUNT: begin
          cnt_a <= nxt_a;
          cnt_b <= nxt_b;
          if (tmr == '0) begin
            state     <= ST_CMP;
            ro_enable <= 1'b0;
            ro_reset  <= 1'b1;
            done      <= 1'b1;
            count_a   <= nxt_a;
            count_b   <= nxt_b;
            response  <= (nxt_a > nxt_b);
            tie       <= (nxt_a == nxt_b);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_CMP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ro_pair_counter.md
# ro_pair_counter

Measures the relative frequency of two ring oscillators and produces one PUF response bit. It sits directly downstream of a pair of `ringoscillator` instances: it drives their `enable`/`reset` inputs, then counts rising edges on their `dffout` outputs over a fixed window of `clk` cycles. It compares the two counts and reports which oscillator is faster. The response bit, a tie flag and both raw counts go to the challenge/response controller.

## Interface
Parameters:
- `CNT_W`, 16, width of each edge counter and count output.
- `WINDOW`, 4096, number of `clk` cycles in the counting window (≥1).
- `SETTLE`, 16, number of `clk` cycles the oscillators run before counting starts (≥1).
- `SYNC_STAGES`, 2, flip-flop depth of each input synchronizer (≥2).

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low; it forces all state to reset values.
- `start` in 1: one-cycle request to begin a measurement; ignored while `busy`.
- `ro_a` in 1: `dffout` of oscillator A; asynchronous to `clk`.
- `ro_b` in 1: `dffout` of oscillator B; asynchronous to `clk`.
- `ro_enable` out 1: drives `enable` of both oscillators.
- `ro_reset` out 1: drives `reset` of both oscillators; active-high.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse; the results are valid from this cycle onward.
- `response` out 1: 1 if count_a > count_b, else 0.
- `tie` out 1: 1 if count_a == count_b.
- `count_a`, `count_b` out CNT_W: edge counts from the last completed window.

## Operation
- FSM states are IDLE, SETTLE, COUNT and CMP.
- **IDLE**
  - Outputs: `ro_enable`=0, `ro_reset`=1, `busy`=0.
  - On `start`=1, go to SETTLE, clear both counters and load the timer.
- **SETTLE**
  - Outputs: `ro_enable`=1, `ro_reset`=0, `busy`=1.
  - Stay for SETTLE cycles, then go to COUNT and load the timer with WINDOW.
- **COUNT**
  - Outputs: as in SETTLE.
  - Counting: each cycle with a detected rising edge on the synchronized `ro_a` increments counter A; counter B works the same for `ro_b`. Both can increment in the same cycle.
  - Exit: after WINDOW cycles, go to CMP.
- **CMP**
  - Outputs: one cycle; `ro_enable`=0, `ro_reset`=1, `busy`=1, `done`=1.
  - Results: `count_a`/`count_b` take the counter values, and `response`/`tie` are computed from them.
  - Exit: next state is IDLE.
- Counters saturate at 2^CNT_W−1 and do not wrap. If both counters saturate, `tie`=1 and `response`=0.
- Result outputs hold until the next CMP. They do not change during a new measurement.
- Edge detection:
  - Mechanism: an edge is synchronized-sample = 1 with previous sample = 0.
  - Input assumption: the input frequency must be below clk/2; faster inputs alias, and this is not checked.
  - Continuity: the synchronizer and history register run in every state, so the first COUNT cycle does not see a spurious edge.
- `start` during SETTLE, COUNT or CMP is dropped and not queued. `start` in the same cycle that CMP returns to IDLE is also dropped.
- Reset asserted mid-operation:
  - It returns the FSM to IDLE immediately and asynchronously.
  - It clears all outputs to their reset values.
  - No `done` is produced.

## Timing
- Reset values:
  - `ro_enable`=0, `ro_reset`=1.
  - `busy`=0, `done`=0.
  - `response`=0, `tie`=0.
  - `count_a`=0, `count_b`=0.
  - FSM in IDLE, synchronizers at 0.
- Measurement sequence, with `start` sampled high at edge k:
  - `ro_enable` rises and `busy` rises after edge k.
  - COUNT occupies the cycles after edges k+SETTLE … k+SETTLE+WINDOW−1.
  - `done` is high for the cycle after edge k+SETTLE+WINDOW.
- Total latency is SETTLE+WINDOW+1 cycles from the start edge to the done cycle.
- An input edge reaches the edge detector SYNC_STAGES+1 cycles after it occurs. The window boundary is defined on detector output, not on raw pins.
- All outputs are registered.

## Structure
- Package `ro_puf_pkg` holds:
  - the FSM state enum (IDLE, SETTLE, COUNT, CMP);
  - the default values of CNT_W, WINDOW, SETTLE and SYNC_STAGES;
  - a timer-width function, clog2(max(WINDOW, SETTLE)).
- One sub-module, `ro_edge_sync`, provides the SYNC_STAGES-deep synchronizer plus a rising-edge pulse output. It is instantiated twice, once for `ro_a` and once for `ro_b`.
- One shared down-counting timer serves both SETTLE and COUNT.

## Test plan
- **Frequency difference:** WINDOW=400, SETTLE=16; `ro_a` period 8 clk, `ro_b` period 10 clk → `count_a`=50±1, `count_b`=40±1, `response`=1, `tie`=0. `done` is exactly 417 cycles after the start edge.
- **Swapped periods:** same setup with the periods swapped → `response`=0, `tie`=0.
- **Equal periods:** both inputs period 8 and in phase → `count_a`==`count_b`, `tie`=1, `response`=0.
- **Start while busy:** pulse `start` during SETTLE and during COUNT → one `done` only. `busy` stays continuous and the results match a single measurement.
- **Reset mid-COUNT:** assert `reset` low 100 cycles into COUNT → `ro_enable`=0, `ro_reset`=1 and `busy`=0 in the same cycle, with all results 0. No `done` occurs. A following `start` completes normally.
- **Saturation:** CNT_W=4, WINDOW=400, `ro_a` period 8, `ro_b` period 40 → `count_a`=15 (saturated), `count_b`=10, `response`=1.
